// File: rtl/serial_subtract_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction controller.
// It holds the state encoding and the counter-width helper.
package serial_subtract_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter must be able to hold WIDTH, because it increments once more on the last bit.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_subtracter.sv
// One-bit full subtracter: computes d = a - b - bin and produces the borrow out.
module full_subtracter (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial a - b controller. It drives one full_subtracter LSB first over WIDTH cycles.
// Defining SERIAL_SUB_FLAGS_EN adds registered zero/lt result flags.
module serial_subtract_ctrl
  import serial_subtract_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_FLAGS_EN
  output logic             zero,
  output logic             lt,
`endif
  output logic             bout
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_shift;
  logic             borrow_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fs_d, fs_bout, last_bit;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             or_acc_reg;
`endif

  full_subtracter u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_reg),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  // The new bit enters at the MSB. This form also covers WIDTH == 1.
  always_comb begin
    res_shift            = res_sr >> 1;
    res_shift[WIDTH-1]   = fs_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == ST_RUN);
    done = (state_reg == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      diff       <= '0;
      bout       <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      or_acc_reg <= 1'b0;
      zero       <= 1'b0;
      lt         <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: if (start) begin
          a_sr       <= a;
          b_sr       <= b;
          borrow_reg <= 1'b0;
          cnt_reg    <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
          or_acc_reg <= 1'b0;
`endif
        end
        ST_RUN: begin
          a_sr       <= a_sr >> 1;
          b_sr       <= b_sr >> 1;
          res_sr     <= res_shift;
          borrow_reg <= fs_bout;
          cnt_reg    <= cnt_reg + CNT_W'(1);
`ifdef SERIAL_SUB_FLAGS_EN
          or_acc_reg <= or_acc_reg | fs_d;
`endif
          // The result is captured from the final bit's values so that it is valid during DONE.
          if (last_bit) begin
            diff <= res_shift;
            bout <= fs_bout;
`ifdef SERIAL_SUB_FLAGS_EN
            zero <= ~(or_acc_reg | fs_d);
            lt   <= fs_bout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
